// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle shift-and-add multiplier that borrows the core's
// shared 32-bit ALU. It returns the low 32 bits of op_a*op_b.
// Each iteration takes two cycles: an ADD cycle, then an SLL cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; the ALU is driven with a harmless ADD 0+0
// S_ADD   | acc + mcand on the ALU; the sum is kept only if mplier[0]=1
// S_SHIFT | mcand << 1 on the ALU; mplier >>= 1; iteration count +1
// S_DONE  | one-cycle done pulse; product_lo (= acc) is valid
module alu_mul_seq #(
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] product_lo,
   output logic [31:0] alu_src_a,
   output logic [31:0] alu_src_b,
   output logic [3:0]  alu_control,
   input  logic [31:0] alu_result
);

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SLL = 4'b0111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ADD   = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      state, state_nx;
   logic [31:0] acc;
   logic [31:0] mcand;
   logic [31:0] mplier;
   logic [5:0]  cnt;
   logic [5:0]  cnt_inc;
   logic [31:0] mplier_sh;

   assign cnt_inc    = cnt + 6'd1;
   assign mplier_sh  = {1'b0, mplier[31:1]};
   assign product_lo = acc;
   assign busy       = (state == S_ADD) || (state == S_SHIFT);
   assign done       = (state == S_DONE);

   // State register; a reset aborts any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next-state logic and ALU operand steering.
   always_comb begin
      state_nx    = state;
      alu_control = ALU_ADD;
      alu_src_a   = 32'd0;
      alu_src_b   = 32'd0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (EARLY_EXIT && (op_b == 32'd0)) state_nx = S_DONE;
               else                               state_nx = S_ADD;
            end
         end
         S_ADD: begin
            alu_src_a = acc;
            alu_src_b = mcand;
            state_nx  = S_SHIFT;
         end
         S_SHIFT: begin
            alu_control = ALU_SLL;
            alu_src_a   = mcand;
            alu_src_b   = 32'd1;
            if ((cnt_inc == 6'd32) || (EARLY_EXIT && (mplier_sh == 32'd0)))
               state_nx = S_DONE;
            else
               state_nx = S_ADD;
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Datapath registers. Every arithmetic result comes from the shared ALU.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc    <= 32'd0;
         mcand  <= 32'd0;
         mplier <= 32'd0;
         cnt    <= 6'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  acc    <= 32'd0;
                  mcand  <= op_a;
                  mplier <= op_b;
                  cnt    <= 6'd0;
               end
            end
            S_ADD: begin
               if (mplier[0]) acc <= alu_result;
            end
            S_SHIFT: begin
               mcand  <= alu_result;
               mplier <= mplier_sh;
               cnt    <= cnt_inc;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: runs two multipliers side by side, one with EARLY_EXIT=1
// and one with EARLY_EXIT=0, each wired to its own behavioural ALU. Products,
// latencies, busy time and done pulses are compared against a plain
// arithmetic model.
module tb_alu_mul_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] op_a, op_b;

   logic        busy1, done1, busy0, done0;
   logic [31:0] prod1, prod0;
   logic [31:0] sa1, sb1, sa0, sb0;
   logic [3:0]  ctl1, ctl0;
   logic [31:0] res1, res0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] ctl);
      if (ctl == 4'b0000)      return a + b;
      else if (ctl == 4'b0111) return a << b[4:0];
      else                     return 32'd0;
   endfunction

   assign res1 = alu_f(sa1, sb1, ctl1);
   assign res0 = alu_f(sa0, sb0, ctl0);

   alu_mul_seq #(.EARLY_EXIT(1'b1)) dut_ee1 (
      .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
      .busy(busy1), .done(done1), .product_lo(prod1),
      .alu_src_a(sa1), .alu_src_b(sb1), .alu_control(ctl1), .alu_result(res1));

   alu_mul_seq #(.EARLY_EXIT(1'b0)) dut_ee0 (
      .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
      .busy(busy0), .done(done0), .product_lo(prod0),
      .alu_src_a(sa0), .alu_src_b(sb0), .alu_control(ctl0), .alu_result(res0));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Cycles from the start-sampling edge (counted as 1) until done is seen.
   function automatic int exp_lat(input logic [31:0] b, input bit ee);
      int n;
      if (!ee) return 65;
      if (b == 32'd0) return 1;
      n = 0;
      for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
      return 2 * n + 1;
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input string tag, input bit inject);
      int cyc, lat0, lat1, pul0, pul1, bz0, bz1;
      logic [31:0] exp_p;
      exp_p = a * b;
      @(negedge clk);
      op_a = a; op_b = b; start = 1'b1;
      @(posedge clk);
      cyc = 1;
      @(negedge clk);
      start = 1'b0;
      op_a = $urandom; op_b = $urandom;
      lat0 = -1; lat1 = -1; pul0 = 0; pul1 = 0; bz0 = 0; bz1 = 0;
      while (cyc < 200) begin
         if (done0) begin pul0++; if (lat0 < 0) lat0 = cyc; end
         if (done1) begin pul1++; if (lat1 < 0) lat1 = cyc; end
         if (busy0) bz0++;
         if (busy1) bz1++;
         if (lat0 >= 0 && lat1 >= 0) break;
         if (inject && (cyc == 3 || cyc == 4)) begin
            start = 1'b1; op_a = $urandom; op_b = $urandom | 32'd1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      chk({tag, "_lat_ee1"}, lat1, exp_lat(b, 1'b1));
      chk({tag, "_lat_ee0"}, lat0, exp_lat(b, 1'b0));
      chk({tag, "_prod_ee1"}, prod1, exp_p);
      chk({tag, "_prod_ee0"}, prod0, exp_p);
      chk({tag, "_busy_ee1"}, bz1, exp_lat(b, 1'b1) - 1);
      chk({tag, "_busy_ee0"}, bz0, exp_lat(b, 1'b0) - 1);
      chk({tag, "_pulses_ee1"}, pul1, 1);
      chk({tag, "_pulses_ee0"}, pul0, 1);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_done_off"}, {30'd0, done1, done0}, 32'd0);
      chk({tag, "_hold_ee1"}, prod1, exp_p);
      chk({tag, "_hold_ee0"}, prod0, exp_p);
   endtask

   initial begin
      logic [31:0] ra, rb;
      reset = 1'b1; start = 1'b0; op_a = 32'd0; op_b = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {30'd0, busy1, busy0}, 32'd0);
      chk("rst_done", {30'd0, done1, done0}, 32'd0);
      chk("rst_prod1", prod1, 32'd0);
      chk("rst_prod0", prod0, 32'd0);
      chk("rst_alu", {28'd0, ctl1} | sa1 | sb1 | sa0 | sb0 | {28'd0, ctl0}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op(32'd6, 32'd7, "t1_6x7", 1'b0);
      chk("t1_const", prod1, 32'd42);
      run_op(32'd123, 32'd0, "t2_zero", 1'b0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "t3_ones", 1'b0);
      chk("t3_const", prod1, 32'h0000_0001);
      run_op(32'h0001_0000, 32'h0001_0000, "t4_ovf", 1'b0);
      run_op(32'd1000, 32'h8000_0003, "t5_inject", 1'b1);

      // Abort a long operation while it sits in SHIFT.
      @(negedge clk);
      op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("t6_in_shift", {28'd0, ctl1}, 32'd7);
      reset = 1'b1;
      #1;
      chk("t6_busy", {30'd0, busy1, busy0}, 32'd0);
      chk("t6_done", {30'd0, done1, done0}, 32'd0);
      chk("t6_prod", prod1 | prod0, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("t6_no_done", {30'd0, done1, done0}, 32'd0);
      reset = 1'b0;
      run_op(32'd5, 32'd3, "t6_after", 1'b0);
      chk("t6_const", prod1, 32'd15);

      for (int i = 0; i < 700; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 32);
         run_op(ra, rb, $sformatf("rnd%0d", i), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
